// File: rtl/aes_pkg.sv
// Shared AES types and the key-schedule round constant table.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

    // Vectors are descending; bit 127 of a block is the first bit on the wire,
    // so word w0 occupies [127:96] and byte b0 of a word occupies [31:24].
    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   aes_byte_t;
    typedef logic [3:0]   round_idx_t;

    // Round constant for key-schedule round N; indices outside 1..10 yield zero.
    function automatic aes_byte_t rcon(input round_idx_t r);
        aes_byte_t c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, its substitution out.
// Latency: combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t y
);

    // Full 256-entry substitution table.
    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
            8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
            8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
            8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
            8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
            8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
            8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
            8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
            8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
            8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
            8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
            8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
            8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
            8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
            8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
            8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
            8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
            8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
            8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
            8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
            8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
            8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
            8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
            8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
            8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
            8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
            8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
            8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
            8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
            8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
            8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
            8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
            8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_key_expand_round.sv
// One AES-128 key-schedule round: round key N from round key N-1 and index N.
// Latency: 1 clock from valid_in to valid_out; one key accepted per clock.
// Backpressure: none; key_out holds its value while valid_in is low.
module aes_key_expand_round
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   round,
    output logic [127:0] key_out,
    output logic         valid_out
);

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  rot, sub, t;
    aes_word_t  n0, n1, n2, n3;
    aes_block_t key_next;

    // Word w0 is the most significant word of the block.
    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord: the leading byte moves to the tail.
    assign rot = {w3[23:0], w3[31:24]};

    // SubWord: one S-box per byte lane.
    aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

    // The round constant only touches the leading byte of the word.
    assign t = sub ^ {rcon(round_idx_t'(round)), 24'h000000};

    // Each new word folds in the one produced just before it.
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_next = {n0, n1, n2, n3};

    // Capture a new key on valid_in; otherwise hold it and drop the valid flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                key_out <= key_next;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_round.sv
// Directed bench for one AES-128 key-schedule round using FIPS-197 vectors.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
// Reset is also checked mid-cycle to confirm it acts without waiting for a clock.
module tb_aes_key_expand_round;

    logic         clock = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [127:0] key_in;
    logic [3:0]   round;
    logic [127:0] key_out;
    logic         valid_out;

    int total = 0;
    int bad   = 0;

    // FIPS-197 appendix A.1 key expansion, round keys 0..10.
    logic [127:0] rk [0:10];

    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R0  = 128'h63636363636363636363636363636363;
    localparam logic [127:0] OTHER    = 128'hdeadbeef0123456789abcdeffedcba98;

    aes_key_expand_round dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .key_in    (key_in),
        .round     (round),
        .key_out   (key_out),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

    task automatic chk_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] k, input logic [3:0] r);
        valid_in = v;
        key_in   = k;
        round    = r;
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b1;
        drive(1'b0, '0, 4'd0);
        #12;
        chk_key("reset_key", key_out, '0);
        chk_bit("reset_vld", valid_out, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // FIPS-197 first round.
        drive(1'b1, rk[0], 4'd1);
        @(negedge clock);
        chk_key("fips_r1_key", key_out, rk[1]);
        chk_bit("fips_r1_vld", valid_out, 1'b1);

        // Last round, rcon 36.
        drive(1'b1, rk[9], 4'd10);
        @(negedge clock);
        chk_key("fips_r10_key", key_out, rk[10]);
        chk_bit("fips_r10_vld", valid_out, 1'b1);

        // All-zero key at the rcon boundaries.
        drive(1'b1, '0, 4'd1);
        @(negedge clock);
        chk_key("zero_r1", key_out, ZERO_R1);
        drive(1'b1, '0, 4'd0);
        @(negedge clock);
        chk_key("zero_r0", key_out, ZERO_R0);
        drive(1'b1, '0, 4'd15);
        @(negedge clock);
        chk_key("zero_r15", key_out, ZERO_R0);

        // Hold: a valid key then five idle cycles with changing inputs.
        drive(1'b1, rk[0], 4'd1);
        @(negedge clock);
        chk_key("hold_load", key_out, rk[1]);
        drive(1'b0, OTHER, 4'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk_key("hold_key", key_out, rk[1]);
            chk_bit("hold_vld", valid_out, 1'b0);
        end

        // Full chain: output looped back with rounds 1..10 on consecutive clocks.
        drive(1'b1, rk[0], 4'd1);
        for (int r = 1; r <= 10; r++) begin
            @(negedge clock);
            chk_bit("chain_vld", valid_out, 1'b1);
            chk_key("chain_key", key_out, rk[r]);
            if (r < 10) begin
                drive(1'b1, key_out, 4'(r + 1));
            end
        end
        drive(1'b0, '0, 4'd0);
        @(negedge clock);
        chk_bit("chain_end_vld", valid_out, 1'b0);
        chk_key("chain_end_key", key_out, rk[10]);

        // Asynchronous reset mid-cycle with a nonzero key and a key in flight.
        drive(1'b1, rk[0], 4'd1);
        @(posedge clock);
        #3;
        chk_key("pre_reset_key", key_out, rk[1]);
        drive(1'b1, rk[9], 4'd10);
        reset = 1'b1;
        #1;
        chk_key("async_reset_key", key_out, '0);
        chk_bit("async_reset_vld", valid_out, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk_key("reset_held_key", key_out, '0);
        chk_bit("reset_held_vld", valid_out, 1'b0);
        reset = 1'b0;
        drive(1'b1, rk[9], 4'd10);
        @(negedge clock);
        chk_key("post_reset_key", key_out, rk[10]);
        chk_bit("post_reset_vld", valid_out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
